// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: operation select, mode commands, control word layout and FSM states.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        SUM = 2'd0,
        AND = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } alu_sel_e;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        CMP_OFF  = 3'd1,
        CMP_ON   = 3'd2,
        SIGN_OFF = 3'd3,
        SIGN_ON  = 3'd4,
        CLR_CMP  = 3'd5
    } mode_cmd_e;

    // Field order matches the ctrl bus, bit 7 down to bit 0.
    typedef struct packed {
        alu_sel_e sel;
        logic     high;
        logic     io;
        logic     ib;
        logic     zb;
        logic     ia;
        logic     za;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per step.
// prod holds {hi, lo}; for divide lo is the quotient and rem the remainder.
module seq_alu_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   ma,
    input  logic [WIDTH-1:0]   mb,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   rem,
    output logic               last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] den_r;
    logic             div_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sh_s;
    logic             ge_s;
    logic [WIDTH-1:0] sub_s;

    assign add_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, den_r} : {(WIDTH+1){1'b0}});
    assign sh_s  = {hi_r, lo_r[WIDTH-1]};
    assign ge_s  = (sh_s >= {1'b0, den_r});
    // Partial remainder stays below the divisor, so the low WIDTH bits are exact.
    assign sub_s = sh_s[WIDTH-1:0] - den_r;

    // Engine registers: load operands, then advance one bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r  <= '0;
            lo_r  <= '0;
            den_r <= '0;
            div_r <= 1'b0;
            cnt_r <= '0;
        end else if (load) begin
            hi_r  <= '0;
            lo_r  <= is_div ? ma : mb;
            den_r <= is_div ? mb : ma;
            div_r <= is_div;
            cnt_r <= '0;
        end else if (step) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (div_r) begin
                hi_r <= ge_s ? sub_s : sh_s[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], ge_s};
            end else begin
                {hi_r, lo_r} <= {add_s, lo_r[WIDTH-1:1]};
            end
        end
    end

    assign prod = {hi_r, lo_r};
    assign rem  = hi_r;
    assign last = (cnt_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: sum/and in one pass, mul/div on an iterative engine, registered result and flags.
// Optional SEQ_ALU_FAST_MUL_EN: multiply becomes a single-cycle array; divide stays iterative.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       ctrl,
    input  logic [2:0]       mode_cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic             carryout,
    output logic             overout,
    output logic             zeroout,
    output logic             divzero,
    output logic             cmpo
);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        mag = (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    alu_ctrl_t          ctrl_s;
    state_e             state_r, state_nx_s;
    logic [WIDTH-1:0]   xa_s, xb_s, op_xa_r, op_xb_r;
    alu_sel_e           op_sel_r;
    logic               op_high_r, op_io_r, op_signed_r, op_cin_r;
    logic               cmp_mode_r, signed_mode_r;
    logic               accept_s, busy_s, step_s, fin_s, load_s, short_op_s;
    logic               eng_last_s;
    logic [2*WIDTH-1:0] eng_prod_s, prod_mag_s, prod_s;
    logic [WIDTH-1:0]   eng_rem_s, eng_ma_s, eng_mb_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   quo_s, rem_s, sel_val_s, res_s;
    logic               sa_s, sb_s;
    logic [WIDTH-1:0]   result_r;
    logic               carry_r, over_r, zero_r, divzero_r, done_r;

    assign ctrl_s = alu_ctrl_t'(ctrl);
    assign xa_s   = (ctrl_s.za ? {WIDTH{1'b0}} : a) ^ {WIDTH{ctrl_s.ia}};
    assign xb_s   = (ctrl_s.zb ? {WIDTH{1'b0}} : b) ^ {WIDTH{ctrl_s.ib}};

`ifdef SEQ_ALU_FAST_MUL_EN
    assign short_op_s = (ctrl_s.sel != DIV);
`else
    assign short_op_s = (ctrl_s.sel == SUM) || (ctrl_s.sel == AND);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = short_op_s ? FIN : ITER;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ITER: begin
                if (eng_last_s) begin
                    state_nx_s = FIN;
                end else begin
                    state_nx_s = ITER;
                end
            end
            FIN:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM-derived control strobes.
    always_comb begin
        accept_s = 1'b0;
        busy_s   = 1'b0;
        step_s   = 1'b0;
        fin_s    = 1'b0;
        case (state_r)
            IDLE:    accept_s = start;
            ITER: begin
                busy_s = 1'b1;
                step_s = 1'b1;
            end
            FIN: begin
                busy_s = 1'b1;
                fin_s  = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
    end

    assign load_s   = accept_s && !short_op_s;
    assign eng_ma_s = mag(xa_s, signed_mode_r);
    // A zero divisor is replaced by 1 so the quotient is the dividend and the remainder 0.
    assign eng_mb_s = (ctrl_s.sel == DIV && xb_s == {WIDTH{1'b0}}) ? WIDTH'(1) : mag(xb_s, signed_mode_r);

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .step   (step_s),
        .is_div (ctrl_s.sel == DIV),
        .ma     (eng_ma_s),
        .mb     (eng_mb_s),
        .prod   (eng_prod_s),
        .rem    (eng_rem_s),
        .last   (eng_last_s)
    );

`ifdef SEQ_ALU_FAST_MUL_EN
    assign prod_mag_s = {{WIDTH{1'b0}}, mag(op_xa_r, op_signed_r)} * {{WIDTH{1'b0}}, mag(op_xb_r, op_signed_r)};
`else
    assign prod_mag_s = eng_prod_s;
`endif

    // Sign fix-up on magnitudes: quotient/product by sign(a)^sign(b), remainder follows the dividend.
    assign sa_s   = op_signed_r & op_xa_r[WIDTH-1];
    assign sb_s   = op_signed_r & op_xb_r[WIDTH-1];
    assign prod_s = (sa_s ^ sb_s) ? -prod_mag_s : prod_mag_s;
    assign quo_s  = (sa_s ^ sb_s) ? -eng_prod_s[WIDTH-1:0] : eng_prod_s[WIDTH-1:0];
    assign rem_s  = sa_s ? -eng_rem_s : eng_rem_s;
    assign sum_s  = {1'b0, op_xa_r} + {1'b0, op_xb_r} + {{WIDTH{1'b0}}, op_cin_r};

    // Result select and output inversion.
    always_comb begin
        sel_val_s = {WIDTH{1'b0}};
        case (op_sel_r)
            SUM:     sel_val_s = sum_s[WIDTH-1:0];
            AND:     sel_val_s = op_xa_r & op_xb_r;
            MUL:     sel_val_s = op_high_r ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
            DIV:     sel_val_s = op_high_r ? rem_s : quo_s;
            default: sel_val_s = {WIDTH{1'b0}};
        endcase
        res_s = sel_val_s ^ {WIDTH{op_io_r}};
    end

    // Operand latch at start, result and flags at completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_xa_r     <= '0;
            op_xb_r     <= '0;
            op_sel_r    <= SUM;
            op_high_r   <= 1'b0;
            op_io_r     <= 1'b0;
            op_signed_r <= 1'b0;
            op_cin_r    <= 1'b0;
            result_r    <= '0;
            carry_r     <= 1'b0;
            over_r      <= 1'b0;
            zero_r      <= 1'b1;
            divzero_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= fin_s;
            if (accept_s) begin
                op_xa_r     <= xa_s;
                op_xb_r     <= xb_s;
                op_sel_r    <= ctrl_s.sel;
                op_high_r   <= ctrl_s.high;
                op_io_r     <= ctrl_s.io;
                op_signed_r <= signed_mode_r;
                op_cin_r    <= cmp_mode_r & carryin;
            end
            if (fin_s) begin
                result_r <= res_s;
                carry_r  <= (op_sel_r == SUM) & sum_s[WIDTH];
                over_r   <= (~res_s[WIDTH-1] & op_xa_r[WIDTH-1] & op_xb_r[WIDTH-1]) |
                            (res_s[WIDTH-1] & ~op_xa_r[WIDTH-1] & ~op_xb_r[WIDTH-1]);
                zero_r   <= (res_s == {WIDTH{1'b0}});
                if (op_sel_r == DIV) begin
                    divzero_r <= (op_xb_r == {WIDTH{1'b0}});
                end
            end
        end
    end

    // Mode registers, updated on any cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_mode_r    <= 1'b0;
            signed_mode_r <= 1'b0;
        end else begin
            case (mode_cmd)
                CMP_OFF:  cmp_mode_r    <= 1'b0;
                CMP_ON:   cmp_mode_r    <= 1'b1;
                SIGN_OFF: signed_mode_r <= 1'b0;
                SIGN_ON:  signed_mode_r <= 1'b1;
                default:  cmp_mode_r    <= cmp_mode_r;
            endcase
        end
    end

    assign busy     = busy_s;
    assign done     = done_r;
    assign aluout   = oe ? result_r : {WIDTH{1'b0}};
    assign carryout = carry_r;
    assign overout  = over_r;
    assign zeroout  = zero_r;
    assign divzero  = divzero_r;
    assign cmpo     = oe | cmp_mode_r | (mode_cmd == CLR_CMP);

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu (WIDTH=8) plus hand sequences for handshake corners.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst, start, carryin, oe;
    logic [7:0] ctrl, a, b;
    logic [2:0] mode_cmd;
    logic       busy, done, carryout, overout, zeroout, divzero, cmpo;
    logic [7:0] aluout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ctrl     (ctrl),
        .mode_cmd (mode_cmd),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .oe       (oe),
        .busy     (busy),
        .done     (done),
        .aluout   (aluout),
        .carryout (carryout),
        .overout  (overout),
        .zeroout  (zeroout),
        .divzero  (divzero),
        .cmpo     (cmpo)
    );

    typedef struct {
        logic [2:0] mode;
        logic [7:0] ctrl;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        int         intr;
        logic [7:0] y;
        logic       c;
        logic       o;
        logic       z;
        logic       dz;
        int         lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_mode(input logic [2:0] m);
        @(negedge clk);
        mode_cmd = m;
        @(negedge clk);
        mode_cmd = 3'd0;
    endtask

    // Issue one op; lat = clock edges after the start-sampling edge until done is seen.
    // intr>0 injects a start plus a SIGN_OFF command at that point of the op.
    task automatic do_op(input logic [7:0] c, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input int intr, output int lat);
        @(negedge clk);
        ctrl = c; a = av; b = bv; carryin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (intr != 0 && lat == intr) begin
                start = 1'b1; ctrl = 8'h00; a = 8'h11; b = 8'h22; mode_cmd = 3'd3;
            end else begin
                start = 1'b0; mode_cmd = 3'd0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        mode_cmd = 3'd0;
    endtask

    initial begin
        int lat;
        int cnt;
        logic seen;

        //            mode   ctrl   a      b      cin intr y      c     o     z     dz    lat
        vecs[0]  = '{3'd3, 8'h00, 8'hF0, 8'h20, 1'b0, 0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{3'd3, 8'h40, 8'hCC, 8'hAA, 1'b0, 0, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{3'd3, 8'h80, 8'h10, 8'h20, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9};
        vecs[3]  = '{3'd3, 8'hA0, 8'h10, 8'h20, 1'b0, 0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[4]  = '{3'd3, 8'hA0, 8'hFF, 8'hFF, 1'b0, 0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[5]  = '{3'd4, 8'hC0, 8'hF9, 8'h02, 1'b0, 3, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[6]  = '{3'd4, 8'hE0, 8'hF9, 8'h02, 1'b0, 0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[7]  = '{3'd4, 8'h80, 8'hF9, 8'h03, 1'b0, 0, 8'hEB, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[8]  = '{3'd4, 8'hA0, 8'hF9, 8'h03, 1'b0, 0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[9]  = '{3'd4, 8'hC0, 8'h80, 8'hFF, 1'b0, 0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[10] = '{3'd3, 8'hC0, 8'h37, 8'h00, 1'b0, 0, 8'h37, 1'b0, 1'b0, 1'b0, 1'b1, 9};
        vecs[11] = '{3'd3, 8'hE0, 8'h37, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9};
        vecs[12] = '{3'd3, 8'hC0, 8'hC8, 8'h07, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[13] = '{3'd3, 8'hE0, 8'hC8, 8'h07, 1'b0, 0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[14] = '{3'd3, 8'h03, 8'h55, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[15] = '{3'd3, 8'h13, 8'h55, 8'h01, 1'b0, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[16] = '{3'd3, 8'h00, 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[17] = '{3'd3, 8'h4C, 8'h5A, 8'h33, 1'b0, 0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[18] = '{3'd3, 8'h00, 8'h01, 8'h01, 1'b1, 0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1};

        rst = 1'b1; start = 1'b0; ctrl = 8'h00; mode_cmd = 3'd0;
        a = 8'h00; b = 8'h00; carryin = 1'b0; oe = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset aluout",   16'(aluout),   16'h0000);
        chk("reset busy",     16'(busy),     16'h0000);
        chk("reset done",     16'(done),     16'h0000);
        chk("reset zeroout",  16'(zeroout),  16'h0001);
        chk("reset carryout", 16'(carryout), 16'h0000);
        chk("reset overout",  16'(overout),  16'h0000);
        chk("reset divzero",  16'(divzero),  16'h0000);
        chk("reset cmpo oe",  16'(cmpo),     16'h0001);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_mode(vecs[i].mode);
            do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].intr, lat);
            chk($sformatf("v%0d aluout", i),   16'(aluout),   16'(vecs[i].y));
            chk($sformatf("v%0d carryout", i), 16'(carryout), 16'(vecs[i].c));
            chk($sformatf("v%0d overout", i),  16'(overout),  16'(vecs[i].o));
            chk($sformatf("v%0d zeroout", i),  16'(zeroout),  16'(vecs[i].z));
            chk($sformatf("v%0d divzero", i),  16'(divzero),  16'(vecs[i].dz));
            chk($sformatf("v%0d latency", i),  16'(lat),      16'(vecs[i].lat));
        end

        // busy through the multiply iterations, then a back-to-back start in the done cycle
        @(negedge clk);
        ctrl = 8'hA0; a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy === 1'b1 && done === 1'b0) cnt++;
            @(negedge clk);
        end
        chk("mul busy iter cycles", 16'(cnt), 16'd8);
        lat = 8;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("mul done latency", 16'(lat),    16'd9);
        chk("mul done busy",    16'(busy),   16'd0);
        chk("mul done aluout",  16'(aluout), 16'h0002);
        ctrl = 8'h00; a = 8'h02; b = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy", 16'(busy), 16'd1);
        @(negedge clk);
        chk("b2b done",   16'(done),   16'd1);
        chk("b2b aluout", 16'(aluout), 16'h0005);

        // compare mode: carry-in joins the sum; cmpo tracks cmp_mode and the clear pulse
        set_mode(3'd2);
        do_op(8'h00, 8'h01, 8'h01, 1'b1, 0, lat);
        chk("cmp sum aluout", 16'(aluout), 16'h0003);
        oe = 1'b0;
        #1;
        chk("cmp cmpo on",     16'(cmpo),   16'd1);
        chk("oe0 aluout zero", 16'(aluout), 16'h0000);
        set_mode(3'd1);
        #1;
        chk("cmpo off", 16'(cmpo), 16'd0);
        @(negedge clk);
        mode_cmd = 3'd5;
        #1;
        chk("clr cmp pulse", 16'(cmpo), 16'd1);
        @(negedge clk);
        mode_cmd = 3'd0;
        #1;
        chk("clr cmp after", 16'(cmpo), 16'd0);
        oe = 1'b1;

        // reset in the 4th divide iteration aborts with no done pulse
        @(negedge clk);
        ctrl = 8'hC0; a = 8'h37; b = 8'h05; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", 16'(busy), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy",   16'(busy),   16'd0);
        chk("abort done",   16'(done),   16'd0);
        chk("abort aluout", 16'(aluout), 16'h0000);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("abort no done", 16'(seen), 16'd0);
        do_op(8'h00, 8'h05, 8'h03, 1'b0, 0, lat);
        chk("post-abort aluout",  16'(aluout), 16'h0008);
        chk("post-abort latency", 16'(lat),    16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
